// File: rtl/bcd_addsub_seq_pkg.sv
// Shared state encodings and BCD constants for the digit-serial BCD adder/subtractor.
package bcd_addsub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] ADJ_ADD = 4'd6;
  localparam logic [3:0] ADJ_SUB = 4'd10;

endpackage

// File: rtl/bcd_addsub_seq_digit.sv
// One decimal digit of add/subtract with 6502 carry semantics (carry = no borrow on subtract).
module bcd_digit_addsub
  import bcd_addsub_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] sum,
  output logic       cout,
  output logic       bad
);

  logic [4:0] raw_add;
  logic [5:0] raw_sub;

  // Non-BCD digits fall through the same formulas, truncated mod 16.
  always_comb begin
    raw_add = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    raw_sub = {2'b0, a} - {2'b0, b} - {5'b0, ~cin};
    bad     = (a > BCD_MAX) || (b > BCD_MAX);
    sum     = raw_add[3:0];
    cout    = 1'b0;
    if (sub) begin
      if (raw_sub[5]) begin
        sum  = raw_sub[3:0] + ADJ_SUB;
        cout = 1'b0;
      end else begin
        sum  = raw_sub[3:0];
        cout = 1'b1;
      end
    end else if (raw_add > {1'b0, BCD_MAX}) begin
      sum  = raw_add[3:0] + ADJ_ADD;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor: one nibble per clock, LSD first, start/done handshake.
module bcd_addsub_seq
  import bcd_addsub_seq_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, result_q, result_d;
  logic               sub_q, sub_d, carry_q, carry_d;
  logic               cout_q, cout_d, zero_q, zero_d, invalid_q, invalid_d;

  logic               accept, last;
  logic [3:0]         op_a, op_b, dig_sum;
  logic               dig_cout, dig_bad;

  assign accept = start && (state_q != ST_RUN);
  assign last   = (idx_q == IDX_W'(DIGITS - 1));

  bcd_digit_addsub u_digit (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry_q),
    .sub  (sub_q),
    .sum  (dig_sum),
    .cout (dig_cout),
    .bad  (dig_bad)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        op_a = a_q[i*4 +: 4];
        op_b = b_q[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // cout and zero are only committed on the last digit so they stay stable through DONE and after.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    if (accept) begin
      a_d       = a;
      b_d       = b;
      sub_d     = sub;
      carry_d   = cin;
      idx_d     = '0;
      result_d  = '0;
      invalid_d = 1'b0;
      cout_d    = 1'b0;
      zero_d    = 1'b0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) result_d[i*4 +: 4] = dig_sum;
      end
      carry_d   = dig_cout;
      invalid_d = invalid_q | dig_bad;
      idx_d     = idx_q + 1'b1;
      if (last) begin
        cout_d = dig_cout;
        zero_d = (result_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      invalid_q <= 1'b0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
    end
  end

  assign result  = result_q;
  assign cout    = cout_q;
  assign zero    = zero_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq: a 4-digit and a 1-digit instance checked against expected values.
module tb_bcd_addsub_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s4_start, s4_sub, s4_cin;
  logic [15:0] s4_a, s4_b, d4_res;
  logic        d4_busy, d4_done, d4_cout, d4_zero, d4_inv;

  logic        s1_start, s1_sub, s1_cin;
  logic [3:0]  s1_a, s1_b, d1_res;
  logic        d1_busy, d1_done, d1_cout, d1_zero, d1_inv;

  bcd_addsub_seq #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .cin(s4_cin),
    .a(s4_a), .b(s4_b), .busy(d4_busy), .done(d4_done), .result(d4_res),
    .cout(d4_cout), .zero(d4_zero), .invalid(d4_inv)
  );

  bcd_addsub_seq #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .cin(s1_cin),
    .a(s1_a), .b(s1_b), .busy(d1_busy), .done(d1_done), .result(d1_res),
    .cout(d1_cout), .zero(d1_zero), .invalid(d1_inv)
  );

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        zero;
    logic        inv;
    int          due;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int pcyc = 0;
  int checks = 0;
  int passes = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, pcyc);
  endtask

  task automatic checkDone(input string tag, input exp_t e, input logic [31:0] res,
                           input logic co, input logic z, input logic iv);
    checkOutput({tag, " result"}, res, e.res);
    checkOutput({tag, " cout"}, {31'b0, co}, {31'b0, e.cout});
    checkOutput({tag, " zero"}, {31'b0, z}, {31'b0, e.zero});
    checkOutput({tag, " invalid"}, {31'b0, iv}, {31'b0, e.inv});
    checkOutput({tag, " done cycle"}, pcyc, e.due);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (d4_done === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        $display("[TB] FAIL d4 unexpected done: got done=1, expected done=0 (cycle %0d)", pcyc);
      end else begin
        e = q4.pop_front();
        checkDone("d4", e, {16'b0, d4_res}, d4_cout, d4_zero, d4_inv);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (d1_done === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("[TB] FAIL d1 unexpected done: got done=1, expected done=0 (cycle %0d)", pcyc);
      end else begin
        e = q1.pop_front();
        checkDone("d1", e, {28'b0, d1_res}, d1_cout, d1_zero, d1_inv);
      end
    end
  end

  function automatic int bcd2int(input logic [31:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int x, input int nd);
    logic [31:0] r = '0;
    int t = x;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: operate on integers, wrap modulo 10^digits.
  task automatic model(input int nd, input logic s, input logic c, input logic [31:0] av,
                       input logic [31:0] bv, output logic [31:0] res, output logic co);
    int m = 1;
    int r;
    for (int i = 0; i < nd; i++) m = m * 10;
    if (!s) begin
      r  = bcd2int(av, nd) + bcd2int(bv, nd) + (c ? 1 : 0);
      co = (r >= m);
      if (co) r = r - m;
    end else begin
      r  = bcd2int(av, nd) - bcd2int(bv, nd) - (c ? 0 : 1);
      co = (r >= 0);
      if (!co) r = r + m;
    end
    res = int2bcd(r, nd);
  endtask

  task automatic waitDrain(input int nd);
    int n = 0;
    while (((nd == 4) ? q4.size() : q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      $display("[TB] FAIL d%0d done timeout: got no done, expected done within 40 cycles", nd);
      q4.delete();
      q1.delete();
    end
  endtask

  task automatic pushExp(input int nd, input logic [31:0] er, input logic ec, input logic ei, input int due);
    exp_t e;
    e.res  = er;
    e.cout = ec;
    e.zero = (er == 32'd0);
    e.inv  = ei;
    e.due  = due;
    if (nd == 4) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic applyStimulus(input int nd, input logic s, input logic c, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] er, input logic ec,
                               input logic ei);
    @(negedge clk);
    pushExp(nd, er, ec, ei, pcyc + nd + 1);
    if (nd == 4) begin
      s4_start = 1'b1; s4_sub = s; s4_cin = c; s4_a = av[15:0]; s4_b = bv[15:0];
    end else begin
      s1_start = 1'b1; s1_sub = s; s1_cin = c; s1_a = av[3:0]; s1_b = bv[3:0];
    end
    @(negedge clk);
    s4_start = 1'b0;
    s1_start = 1'b0;
    waitDrain(nd);
  endtask

  initial begin
    int p;
    logic [31:0] av, bv, er;
    logic ec, rs, rc;

    rst_n = 1'b0;
    s4_start = 1'b0; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = '0; s4_b = '0;
    s1_start = 1'b0; s1_sub = 1'b0; s1_cin = 1'b0; s1_a = '0; s1_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("d4 reset busy", {31'b0, d4_busy}, 32'd0);
    checkOutput("d4 reset done", {31'b0, d4_done}, 32'd0);
    checkOutput("d4 reset result", {16'b0, d4_res}, 32'd0);
    checkOutput("d4 reset flags", {29'b0, d4_cout, d4_zero, d4_inv}, 32'd0);
    checkOutput("d1 reset outputs", {25'b0, d1_busy, d1_done, d1_cout, d1_zero, d1_inv, 2'b0}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(4, 1'b0, 1'b0, 32'h1234, 32'h8766, 32'h0000, 1'b1, 1'b0);
    applyStimulus(4, 1'b1, 1'b1, 32'h1000, 32'h0001, 32'h0999, 1'b1, 1'b0);
    applyStimulus(4, 1'b1, 1'b1, 32'h0000, 32'h0001, 32'h9999, 1'b0, 1'b0);
    applyStimulus(4, 1'b0, 1'b0, 32'h00A0, 32'h0001, 32'h0101, 1'b0, 1'b1);
    applyStimulus(4, 1'b0, 1'b0, 32'h0001, 32'h0002, 32'h0003, 1'b0, 1'b0);
    applyStimulus(4, 1'b1, 1'b0, 32'h5000, 32'h4999, 32'h0000, 1'b1, 1'b0);
    applyStimulus(4, 1'b0, 1'b1, 32'h9999, 32'h0000, 32'h0000, 1'b1, 1'b0);

    applyStimulus(1, 1'b0, 1'b1, 32'h9, 32'h9, 32'h9, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 32'h0, 32'h1, 32'h9, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 32'hC, 32'h1, 32'h3, 1'b1, 1'b1);

    // start pulsed mid-RUN with different operands must be ignored
    @(negedge clk);
    pushExp(4, 32'h0009, 1'b0, 1'b0, pcyc + 5);
    s4_start = 1'b1; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = 16'h0005; s4_b = 16'h0004;
    @(negedge clk);
    s4_start = 1'b0;
    @(negedge clk);
    s4_start = 1'b1; s4_a = 16'h1111; s4_b = 16'h1111;
    @(negedge clk);
    s4_start = 1'b0;
    checkOutput("d4 busy mid-run", {31'b0, d4_busy}, 32'd1);
    waitDrain(4);
    repeat (8) @(negedge clk);

    // start held through DONE: second operation follows with no idle gap
    @(negedge clk);
    p = pcyc;
    pushExp(4, 32'h1000, 1'b0, 1'b0, p + 5);
    s4_start = 1'b1; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = 16'h0123; s4_b = 16'h0877;
    @(negedge clk);
    pushExp(4, 32'h0377, 1'b1, 1'b0, p + 10);
    s4_sub = 1'b1; s4_cin = 1'b1; s4_a = 16'h0500; s4_b = 16'h0123;
    repeat (5) @(negedge clk);
    s4_start = 1'b0;
    checkOutput("d4 busy after back-to-back", {31'b0, d4_busy}, 32'd1);
    waitDrain(4);

    // reset in cycle 2 of RUN aborts with no done
    @(negedge clk);
    s4_start = 1'b1; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = 16'h1111; s4_b = 16'h2222;
    @(negedge clk);
    s4_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("d4 abort busy", {31'b0, d4_busy}, 32'd0);
    checkOutput("d4 abort result", {16'b0, d4_res}, 32'd0);
    checkOutput("d4 abort flags", {28'b0, d4_done, d4_cout, d4_zero, d4_inv}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      for (int sel = 0; sel < 2; sel++) begin
        int nd;
        nd = (sel == 0) ? 4 : 1;
        av = '0;
        bv = '0;
        for (int i = 0; i < nd; i++) begin
          av[i*4 +: 4] = 4'($urandom_range(0, 9));
          bv[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        model(nd, rs, rc, av, bv, er, ec);
        applyStimulus(nd, rs, rc, av, bv, er, ec, 1'b0);
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("d4 scoreboard empty", q4.size(), 32'd0);
    checkOutput("d1 scoreboard empty", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
